fifo_umbral: RTL and testbench

Synchronous FIFO with programmable almost-full/almost-empty thresholds and a per-FIFO error flag. It is instantiated once per buffer of the datapath (Main, VC0, VC1, D0, D1). Its fifo_empty and fifo_error outputs form one bit each of the FSM's FIFO_empties[4:0] and FIFO_errors[4:0] buses. Its threshold inputs are driven from the FSM's afMFs/aeMFs, afVCs/aeVCs or afDs/aeDs registers.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_mem.sv | 50 +++++
 rtl/fifo_umbral.sv | 146 ++++++++++++++
 tb/tb_fifo_umbral.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO constants: default word and pointer widths, reset-time
// almost-full/almost-empty thresholds, and a depth helper. The FSM and all
// five FIFO instances import this so that threshold register widths agree.
package fifo_pkg;

  localparam int unsigned FIFO_DATA_WIDTH = 6;
  localparam int unsigned FIFO_ADDR_WIDTH = 3;

  localparam logic [FIFO_ADDR_WIDTH-1:0] FIFO_AF_DEFAULT = 3'b110;
  localparam logic [FIFO_ADDR_WIDTH-1:0] FIFO_AE_DEFAULT = 3'b011;

  // Number of words addressable by a pointer of the given width.
  function automatic int unsigned fifo_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH register file for fifo_umbral.
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset, clears only the read register
//   we/waddr/wdata  synchronous write port
//   re/raddr/rdata  synchronous read port; rdata holds its value when re=0
// The storage array itself is not reset.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Write port: array has no reset, contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read port: a read of the slot being written in the same cycle returns
  // the old word, which is what the FIFO needs when full with push+pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= {DATA_WIDTH{1'b0}};
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end else begin
      rdata_q <= rdata_q;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fifo_umbral.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds and
// a sticky overflow/underflow error flag.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   init                  loads af_thresh/ae_thresh and clears fifo_error
//   push, data_in         write request and data
//   pop                   read request
//   data_out, valid_out   registered read data, valid one cycle after a pop
//   fifo_empty/fifo_full  count == 0 / count == DEPTH
//   almost_full           count >= af threshold
//   almost_empty          count <= ae threshold
//   fifo_error            sticky error, cleared by reset or init
//   count                 occupancy 0..DEPTH
module fifo_umbral
  import fifo_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int unsigned            ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] AF_DEFAULT = ADDR_WIDTH'(FIFO_AF_DEFAULT),
  parameter logic [ADDR_WIDTH-1:0] AE_DEFAULT = ADDR_WIDTH'(FIFO_AE_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic [ADDR_WIDTH-1:0] af_thresh,
  input  logic [ADDR_WIDTH-1:0] ae_thresh,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  fifo_error,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int unsigned           DEPTH    = fifo_depth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ZERO = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [ADDR_WIDTH-1:0] af_q, af_d;
  logic [ADDR_WIDTH-1:0] ae_q, ae_d;
  logic                  err_q, err_d;
  logic                  valid_q, valid_d;

  logic push_acc_s, pop_acc_s, overflow_s, underflow_s;

  // Accept/reject decisions and next-state values for the control registers.
  always_comb begin
    // At full, a push is still accepted if the same-cycle pop frees a slot.
    push_acc_s  = push && ((count_q != CNT_FULL) || pop);
    pop_acc_s   = pop && (count_q != CNT_ZERO);
    overflow_s  = push && (count_q == CNT_FULL) && !pop;
    // Pop on empty is an underflow even when a push lands in the same cycle.
    underflow_s = pop && (count_q == CNT_ZERO);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    af_d     = af_q;
    ae_d     = ae_q;
    err_d    = err_q;
    valid_d  = pop_acc_s;

    if (push_acc_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_acc_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_acc_s, pop_acc_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // init clears the sticky flag, but an error in the same cycle still sets it.
    if (init) begin
      af_d  = af_thresh;
      ae_d  = ae_thresh;
      err_d = overflow_s || underflow_s;
    end else begin
      af_d  = af_q;
      ae_d  = ae_q;
      err_d = err_q || overflow_s || underflow_s;
    end
  end

  // Control state registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= {ADDR_WIDTH{1'b0}};
      rd_ptr_q <= {ADDR_WIDTH{1'b0}};
      count_q  <= CNT_ZERO;
      af_q     <= AF_DEFAULT;
      ae_q     <= AE_DEFAULT;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
    end
  end

  fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk  (clk),
    .reset(reset),
    .we   (push_acc_s && !reset),
    .waddr(wr_ptr_q),
    .wdata(data_in),
    .re   (pop_acc_s && !reset),
    .raddr(rd_ptr_q),
    .rdata(data_out)
  );

  assign valid_out    = valid_q;
  assign fifo_error   = err_q;
  assign count        = count_q;
  assign fifo_empty   = (count_q == CNT_ZERO);
  assign fifo_full    = (count_q == CNT_FULL);
  assign almost_full  = (count_q >= {1'b0, af_q});
  assign almost_empty = (count_q <= {1'b0, ae_q});

endmodule

// File: tb/tb_fifo_umbral.sv
// Directed self-checking bench for fifo_umbral.
module tb_fifo_umbral;

  logic       clk = 1'b0;
  logic       reset, init, push, pop;
  logic [2:0] af_thresh, ae_thresh;
  logic [5:0] data_in, data_out;
  logic       valid_out, fifo_empty, fifo_full, almost_full, almost_empty, fifo_error;
  logic [3:0] count;
  logic [8:0] st;

  int vec = 0;
  int miscmp = 0;

  always #5 clk = ~clk;

  fifo_umbral dut (
    .clk(clk), .reset(reset), .init(init),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .push(push), .data_in(data_in), .pop(pop),
    .data_out(data_out), .valid_out(valid_out),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .fifo_error(fifo_error), .count(count)
  );

  // status word: {count, full, almost_full, almost_empty, empty, error}
  assign st = {count, fifo_full, almost_full, almost_empty, fifo_empty, fifo_error};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic p, input logic [5:0] d, input logic q);
    push = p; data_in = d; pop = q;
  endtask

  task automatic test_reset();
    reset = 1'b1; init = 1'b0; af_thresh = 3'd0; ae_thresh = 3'd0;
    drive(1'b0, 6'h00, 1'b0);
    tick(); tick();
    reset = 1'b0;
    tick(); tick();
    vec++;
    if (st !== {4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
      miscmp++; $display("FAIL reset_status: got %b expected %b", st, {4'd0, 5'b00110});
    end
    vec++;
    if ({valid_out, data_out} !== 7'd0) begin
      miscmp++; $display("FAIL reset_out: got valid=%b data=%h expected 0/00", valid_out, data_out);
    end
  endtask

  task automatic test_fill_drain();
    logic [8:0] e;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 6'(i), 1'b0);
      tick();
      e = {4'(i), (i == 8), (i >= 6), (i <= 3), 1'b0, 1'b0};
      vec++;
      if (st !== e) begin
        miscmp++; $display("FAIL fill_%0d: got %b expected %b", i, st, e);
      end
    end
    for (int k = 1; k <= 8; k++) begin
      drive(1'b0, 6'h00, 1'b1);
      tick();
      vec++;
      if ({valid_out, data_out, count} !== {1'b1, 6'(k), 4'(8 - k)}) begin
        miscmp++; $display("FAIL drain_%0d: got valid=%b data=%h count=%0d expected 1/%h/%0d",
                           k, valid_out, data_out, count, 6'(k), 8 - k);
      end
    end
    drive(1'b0, 6'h00, 1'b0);
    tick();
    vec++;
    if ({valid_out, data_out, st} !== {1'b0, 6'h08, 4'd0, 5'b00110}) begin
      miscmp++; $display("FAIL drain_idle: got valid=%b data=%h st=%b expected 0/08/000000110",
                         valid_out, data_out, st);
    end
  endtask

  task automatic test_overflow();
    logic [5:0] e;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 6'(6'h10 + i), 1'b0);
      tick();
    end
    drive(1'b1, 6'h2A, 1'b0);
    tick();
    vec++;
    if (st !== {4'd8, 5'b11001}) begin
      miscmp++; $display("FAIL overflow: got %b expected %b", st, {4'd8, 5'b11001});
    end
    drive(1'b1, 6'h30, 1'b1);
    tick();
    vec++;
    if ({valid_out, data_out, st} !== {1'b1, 6'h10, 4'd8, 5'b11001}) begin
      miscmp++; $display("FAIL full_push_pop: got valid=%b data=%h st=%b expected 1/10/100011001",
                         valid_out, data_out, st);
    end
    drive(1'b0, 6'h00, 1'b0);
    init = 1'b1; af_thresh = 3'd6; ae_thresh = 3'd3;
    tick();
    init = 1'b0;
    vec++;
    if (st !== {4'd8, 5'b11000}) begin
      miscmp++; $display("FAIL init_clear: got %b expected %b", st, {4'd8, 5'b11000});
    end
    for (int k = 0; k < 8; k++) begin
      e = (k < 7) ? 6'(6'h11 + k) : 6'h30;
      drive(1'b0, 6'h00, 1'b1);
      tick();
      vec++;
      if ({valid_out, data_out} !== {1'b1, e}) begin
        miscmp++; $display("FAIL ovf_drain_%0d: got valid=%b data=%h expected 1/%h", k, valid_out, data_out, e);
      end
    end
  endtask

  task automatic test_underflow();
    drive(1'b0, 6'h00, 1'b1);
    tick();
    vec++;
    if ({valid_out, st} !== {1'b0, 4'd0, 5'b00111}) begin
      miscmp++; $display("FAIL underflow: got valid=%b st=%b expected 0/000000111", valid_out, st);
    end
    drive(1'b1, 6'h15, 1'b1);
    tick();
    vec++;
    if ({valid_out, st} !== {1'b0, 4'd1, 5'b00101}) begin
      miscmp++; $display("FAIL empty_push_pop: got valid=%b st=%b expected 0/000100101", valid_out, st);
    end
    drive(1'b0, 6'h00, 1'b1);
    tick();
    vec++;
    if ({valid_out, data_out, count} !== {1'b1, 6'h15, 4'd0}) begin
      miscmp++; $display("FAIL empty_pp_read: got valid=%b data=%h count=%0d expected 1/15/0",
                         valid_out, data_out, count);
    end
    drive(1'b0, 6'h00, 1'b0);
    init = 1'b1; af_thresh = 3'd6; ae_thresh = 3'd3;
    tick();
    init = 1'b0;
  endtask

  task automatic test_thresholds();
    logic [8:0] e;
    init = 1'b1; af_thresh = 3'b111; ae_thresh = 3'b001;
    tick();
    init = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      drive(1'b1, 6'(6'h20 + i), 1'b0);
      tick();
      e = {4'(i), 1'b0, (i >= 7), (i <= 1), 1'b0, 1'b0};
      vec++;
      if (st !== e) begin
        miscmp++; $display("FAIL thresh_%0d: got %b expected %b", i, st, e);
      end
    end
    for (int k = 0; k < 7; k++) begin
      drive(1'b0, 6'h00, 1'b1);
      tick();
    end
    drive(1'b0, 6'h00, 1'b0);
    init = 1'b1; af_thresh = 3'd0; ae_thresh = 3'd7;
    tick();
    init = 1'b0;
    vec++;
    if (st !== {4'd0, 5'b01110}) begin
      miscmp++; $display("FAIL af_zero: got %b expected %b", st, {4'd0, 5'b01110});
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] e;
    init = 1'b1; af_thresh = 3'd7; ae_thresh = 3'd1;
    tick();
    init = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 6'(i), 1'b0);
      tick();
    end
    reset = 1'b1;
    drive(1'b1, 6'h3F, 1'b0);
    tick();
    reset = 1'b0;
    drive(1'b0, 6'h00, 1'b0);
    vec++;
    if ({valid_out, data_out, st} !== {1'b0, 6'h00, 4'd0, 5'b00110}) begin
      miscmp++; $display("FAIL reset_mid: got valid=%b data=%h st=%b expected 0/00/000000110",
                         valid_out, data_out, st);
    end
    for (int i = 1; i <= 6; i++) begin
      drive(1'b1, 6'(6'h20 + i), 1'b0);
      tick();
      e = {4'(i), 1'b0, (i >= 6), (i <= 3), 1'b0, 1'b0};
      vec++;
      if (st !== e) begin
        miscmp++; $display("FAIL post_reset_%0d: got %b expected %b", i, st, e);
      end
    end
    for (int k = 1; k <= 6; k++) begin
      drive(1'b0, 6'h00, 1'b1);
      tick();
      vec++;
      if ({valid_out, data_out} !== {1'b1, 6'(6'h20 + k)}) begin
        miscmp++; $display("FAIL post_reset_rd_%0d: got valid=%b data=%h expected 1/%h",
                           k, valid_out, data_out, 6'(6'h20 + k));
      end
    end
    drive(1'b0, 6'h00, 1'b0);
    tick();
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_thresholds();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end

endmodule
